// File: rtl/is_uart_rx_fsm.sv
// UART receiver: oversampled start/data/parity/stop framing with a valid/ack word output.
// Handshake: rx_vld_o is a level that stays high until a cycle with rx_ack_i=1 and no new commit.
module is_uart_rx_fsm #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int PAR_EN    = 1,
  parameter int PAR_ODD   = 0,
  parameter int STOP_BITS = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              uart_ce_i,
  input  logic              rxd_i,
  input  logic              rx_ack_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_vld_o,
  output logic              rx_par_err_o,
  output logic              rx_frm_err_o,
  output logic              rx_ovr_o,
  output logic              rx_busy_o,
  output logic              rxct_r_o
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = (STOP_BITS > 1);
  localparam logic          PAR_ODD_B = (PAR_ODD != 0);
  localparam logic          PAR_EN_B  = (PAR_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PARB  = 3'd3,
    S_STOP  = 3'd4,
    S_WIDL  = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_meta, r_rxs;
  logic [TW-1:0]       r_tick, w_tick_nxt;
  logic [BW-1:0]       r_bit, w_bit_nxt;
  logic                r_stop, w_stop_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_par_f, w_par_f_nxt;
  logic                r_frm_f, w_frm_f_nxt;
  logic                w_commit;
  logic                w_tick_end;
  logic                w_frm_now;
  logic                w_vld_nxt;

  logic [DATA_W-1:0]   r_data;
  logic                r_vld, r_par_err, r_frm_err, r_ovr, r_rxct;

  // rxd_i is asynchronous; the preset-to-1 synchronizer keeps an idle line idle through reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
    end else begin
      r_meta <= rxd_i;
      r_rxs  <= r_meta;
    end
  end

  assign w_tick_end = (r_tick == TICK_END);
  assign w_frm_now  = r_frm_f | ~r_rxs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par_f <= 1'b0;
      r_frm_f <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_stop  <= w_stop_nxt;
      r_shift <= w_shift_nxt;
      r_par_f <= w_par_f_nxt;
      r_frm_f <= w_frm_f_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_stop_nxt  = r_stop;
    w_shift_nxt = r_shift;
    w_par_f_nxt = r_par_f;
    w_frm_f_nxt = r_frm_f;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (uart_ce_i && !r_rxs) begin
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
        end
      end
      S_START: begin
        if (uart_ce_i) begin
          if (r_tick == TICK_MID) begin
            // A start bit that is high again by mid-bit is a glitch, not a frame.
            if (!r_rxs) begin
              w_state_nxt = S_DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
              w_par_f_nxt = 1'b0;
              w_frm_f_nxt = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (uart_ce_i) begin
          if (w_tick_end) begin
            w_shift_nxt = {r_rxs, r_shift[DATA_W-1:1]};
            w_tick_nxt  = '0;
            if (r_bit == BIT_LAST) begin
              w_state_nxt = PAR_EN_B ? S_PARB : S_STOP;
              w_stop_nxt  = 1'b0;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      S_PARB: begin
        if (uart_ce_i) begin
          if (w_tick_end) begin
            w_par_f_nxt = r_rxs != ((^r_shift) ^ PAR_ODD_B);
            w_state_nxt = S_STOP;
            w_stop_nxt  = 1'b0;
            w_tick_nxt  = '0;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (uart_ce_i) begin
          if (w_tick_end) begin
            w_tick_nxt  = '0;
            w_frm_f_nxt = w_frm_now;
            if (r_stop == STOP_LAST) begin
              w_commit    = 1'b1;
              w_state_nxt = w_frm_now ? S_WIDL : S_IDLE;
            end else begin
              w_stop_nxt = 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      S_WIDL: begin
        // A held-low line (break) must go high before another start bit is accepted.
        if (uart_ce_i && r_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Ack in the commit cycle consumes the old word, so it cannot cause an overrun.
  assign w_vld_nxt = w_commit | (r_vld & ~rx_ack_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data    <= '0;
      r_vld     <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr     <= 1'b0;
      r_rxct    <= 1'b1;
    end else begin
      r_rxct <= w_vld_nxt;
      if (w_commit) begin
        r_data    <= r_shift;
        r_vld     <= 1'b1;
        r_par_err <= w_par_f_nxt;
        r_frm_err <= w_frm_f_nxt;
        r_ovr     <= r_vld & ~rx_ack_i;
      end else if (rx_ack_i && r_vld) begin
        r_vld     <= 1'b0;
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
        r_ovr     <= 1'b0;
      end
    end
  end

  assign rx_data_o    = r_data;
  assign rx_vld_o     = r_vld;
  assign rx_par_err_o = r_par_err;
  assign rx_frm_err_o = r_frm_err;
  assign rx_ovr_o     = r_ovr;
  assign rx_busy_o    = (r_state != S_IDLE);
  assign rxct_r_o     = r_rxct;

endmodule
